// File: rtl/rr_arbiter8.sv
// rr_arbiter8: eight-way round-robin arbiter with hold timeout.
// Grants one requester at a time. The grant is held until the owner releases
// it or the hold timeout expires. Every grant is followed by one mandatory
// idle cycle, so two different owners never hold gnt on adjacent cycles.
module rr_arbiter8 #(
  parameter int HOLD_MAX = 16,
  parameter int CW       = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] gnt,
  output logic [2:0] sel,
  output logic       valid,
  output logic       timeout
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    ptr_q, ptr_d;
  logic [CW-1:0] holdCnt_q, holdCnt_d;
  logic [7:0]    gnt_q, gnt_d;
  logic [2:0]    sel_q, sel_d;
  logic          timeout_q, timeout_d;

  logic [15:0]   reqTwice;
  logic [7:0]    rotReq;
  logic [2:0]    offset;
  logic [2:0]    winner;

  // Rotate the request vector so that bit 0 is the current pointer, pick the
  // lowest set bit and add the pointer back to get the winner's index.
  always_comb begin
    reqTwice = {req, req} >> ptr_q;
    rotReq   = reqTwice[7:0];
    offset   = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (rotReq[i]) begin
        offset = 3'(i);
      end
    end
    winner = ptr_q + offset;
  end

  // Next-state and next-output logic for the IDLE/GRANT/RELEASE sequence.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    holdCnt_d = holdCnt_q;
    gnt_d     = gnt_q;
    sel_d     = sel_q;
    timeout_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        gnt_d = 8'h00;
        if (ena && (req != 8'h00)) begin
          gnt_d     = 8'b0000_0001 << winner;
          sel_d     = winner;
          holdCnt_d = CW'(1);
          state_d   = GRANT;
        end
      end
      GRANT: begin
        if (done || !req[sel_q]) begin
          gnt_d     = 8'h00;
          holdCnt_d = '0;
          ptr_d     = sel_q + 3'd1;
          state_d   = RELEASE;
        end else if (holdCnt_q == CW'(HOLD_MAX)) begin
          gnt_d     = 8'h00;
          holdCnt_d = '0;
          ptr_d     = sel_q + 3'd1;
          timeout_d = 1'b1;
          state_d   = RELEASE;
        end else begin
          holdCnt_d = holdCnt_q + CW'(1);
        end
      end
      RELEASE: begin
        gnt_d   = 8'h00;
        state_d = IDLE;
      end
      default: begin
        gnt_d   = 8'h00;
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset clears everything at once, even mid-grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= 3'd0;
      holdCnt_q <= '0;
      gnt_q     <= 8'h00;
      sel_q     <= 3'd0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      holdCnt_q <= holdCnt_d;
      gnt_q     <= gnt_d;
      sel_q     <= sel_d;
      timeout_q <= timeout_d;
    end
  end

  assign gnt     = gnt_q;
  assign sel     = sel_q;
  assign valid   = (gnt_q != 8'h00);
  assign timeout = timeout_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// tb_rr_arbiter8: directed bench for rr_arbiter8 with hand-computed expectations.
module tb_rr_arbiter8;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] req;
  logic       done;
  logic [7:0] gnt;
  logic [2:0] sel;
  logic       valid;
  logic       timeout;

  int checkCount = 0;
  int passCount  = 0;

  rr_arbiter8 #(.HOLD_MAX(16), .CW(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .req     (req),
    .done    (done),
    .gnt     (gnt),
    .sel     (sel),
    .valid   (valid),
    .timeout (timeout)
  );

  // Free-running clock, rising edges at multiples of 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Guard against a run that never finishes.
  initial begin
    #20000;
    $display("[TB] FAIL watchdog: time limit reached, got still running, expected finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic e, input logic [7:0] r, input logic d);
    ena  = e;
    req  = r;
    done = d;
  endtask

  task automatic stepClock();
    @(posedge clk);
    #1;
  endtask

  task automatic checkGrant(input string tag, input logic [7:0] expGnt,
                            input logic [2:0] expSel, input logic expTimeout);
    checkOutput({tag, ".gnt"}, 32'(gnt), 32'(expGnt));
    checkOutput({tag, ".sel"}, 32'(sel), 32'(expSel));
    checkOutput({tag, ".valid"}, 32'(valid), 32'(expGnt != 8'h00));
    checkOutput({tag, ".timeout"}, 32'(timeout), 32'(expTimeout));
  endtask

  initial begin
    logic [2:0] w;
    rst_n = 1'b0;
    applyStimulus(1'b0, 8'h00, 1'b0);

    #3;
    checkGrant("reset_async", 8'h00, 3'd0, 1'b0);
    stepClock();
    stepClock();
    checkGrant("reset_held", 8'h00, 3'd0, 1'b0);
    rst_n = 1'b1;

    // Single request, one-cycle latency, then release by done.
    applyStimulus(1'b1, 8'h04, 1'b0);
    stepClock();
    checkGrant("single_grant", 8'h04, 3'd2, 1'b0);
    applyStimulus(1'b1, 8'h04, 1'b1);
    stepClock();
    checkGrant("single_release", 8'h00, 3'd2, 1'b0);

    // Pointer is now 3: req 1000_0011 must go to 7 first, then 0.
    applyStimulus(1'b1, 8'h83, 1'b0);
    stepClock();
    checkGrant("skip_release_idle", 8'h00, 3'd2, 1'b0);
    stepClock();
    checkGrant("skip_to_7", 8'h80, 3'd7, 1'b0);
    applyStimulus(1'b1, 8'h83, 1'b1);
    stepClock();
    checkGrant("skip_rel7", 8'h00, 3'd7, 1'b0);
    applyStimulus(1'b1, 8'h83, 1'b0);
    stepClock();
    stepClock();
    checkGrant("wrap_to_0", 8'h01, 3'd0, 1'b0);
    applyStimulus(1'b1, 8'h83, 1'b1);
    stepClock();

    // All requesting: pointer is 1, grants go 1,2,...,7,0,1.
    for (int i = 0; i < 9; i++) begin
      w = 3'(1 + i);
      applyStimulus(1'b1, 8'hFF, 1'b0);
      stepClock();
      checkOutput($sformatf("rot%0d_idle.gnt", i), 32'(gnt), 32'h0);
      stepClock();
      checkOutput($sformatf("rot%0d.sel", i), 32'(sel), 32'(w));
      checkOutput($sformatf("rot%0d.gnt", i), 32'(gnt), 32'(8'b1 << w));
      applyStimulus(1'b1, 8'hFF, 1'b1);
      stepClock();
      checkOutput($sformatf("rot%0d_rel.gnt", i), 32'(gnt), 32'h0);
    end

    // Timeout: requester 0 holds for 16 cycles, then forced release.
    applyStimulus(1'b1, 8'h01, 1'b0);
    stepClock();
    stepClock();
    checkGrant("to_grant", 8'h01, 3'd0, 1'b0);
    for (int i = 0; i < 15; i++) begin
      stepClock();
      checkOutput($sformatf("to_hold%0d.gnt", i), 32'(gnt), 32'h01);
      checkOutput($sformatf("to_hold%0d.timeout", i), 32'(timeout), 32'h0);
    end
    stepClock();
    checkGrant("to_forced", 8'h00, 3'd0, 1'b1);
    stepClock();
    checkGrant("to_idle", 8'h00, 3'd0, 1'b0);
    stepClock();
    checkGrant("to_regrant", 8'h01, 3'd0, 1'b0);

    // done on the same edge as the hold limit wins: no timeout pulse.
    for (int i = 0; i < 15; i++) begin
      stepClock();
    end
    checkOutput("tie_prehold.gnt", 32'(gnt), 32'h01);
    applyStimulus(1'b1, 8'h01, 1'b1);
    stepClock();
    checkGrant("tie_release", 8'h00, 3'd0, 1'b0);

    // Enable gating: no new grant while ena=0, but an active grant survives it.
    applyStimulus(1'b0, 8'h10, 1'b0);
    for (int i = 0; i < 5; i++) begin
      stepClock();
      checkOutput($sformatf("ena_off%0d.gnt", i), 32'(gnt), 32'h0);
    end
    applyStimulus(1'b1, 8'h10, 1'b0);
    stepClock();
    checkGrant("ena_grant", 8'h10, 3'd4, 1'b0);
    applyStimulus(1'b0, 8'h10, 1'b0);
    for (int i = 0; i < 3; i++) begin
      stepClock();
      checkOutput($sformatf("ena_hold%0d.gnt", i), 32'(gnt), 32'h10);
    end
    applyStimulus(1'b0, 8'h10, 1'b1);
    stepClock();
    checkGrant("ena_release", 8'h00, 3'd4, 1'b0);

    // Async reset in the middle of a grant to requester 5.
    applyStimulus(1'b1, 8'h20, 1'b0);
    stepClock();
    stepClock();
    checkGrant("ar_grant", 8'h20, 3'd5, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checkGrant("ar_async", 8'h00, 3'd0, 1'b0);
    applyStimulus(1'b1, 8'hFF, 1'b0);
    #1;
    rst_n = 1'b1;
    stepClock();
    checkGrant("ar_first", 8'h01, 3'd0, 1'b0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/rr_arbiter8.md
Name: rr_arbiter8

Overview:
- Round-robin arbiter that shares one 8-way encoded resource select among 8 requesters.
- Produces a one-hot grant plus the matching 3-bit encoded index (sel) and a valid flag for the downstream mux/encoder datapath.
- Grant is held until the owner releases it, or until a hold timeout expires.
- Priority rotates so that each requester is served within 8 grants.

Parameters:
- HOLD_MAX, 16, maximum consecutive GRANT cycles before forced release; legal range 2..255.
- CW, 8, width of the hold counter; must satisfy 2^CW > HOLD_MAX.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- ena  input  1  arbitration enable; 0 blocks new grants only
- req  input  8  request vector, bit i = requester i
- done  input  1  owner release pulse; ignored outside GRANT
- gnt  output  8  one-hot grant, registered
- sel  output  3  binary index of the granted bit, registered
- valid  output  1  1 while gnt is nonzero
- timeout  output  1  one-cycle pulse on a forced release

Behaviour:
- Reset (async, rst_n=0):
  - Outputs: gnt=8'h00, sel=3'b000, valid=0, timeout=0.
  - Internal: state=IDLE, ptr=3'd0, hold counter=0.
  - Takes effect immediately, including mid-grant. Release of reset is sampled synchronously.
- States: IDLE, GRANT, RELEASE.
- IDLE:
  - If ena=1 and req!=0: the winner w is the first set bit scanning indices ptr, ptr+1, ..., wrapping mod 8.
  - Next edge: gnt=1<<w, sel=w, valid=1, counter=1, state=GRANT.
  - Latency is exactly 1 clock from the sampled request to the grant.
  - If ena=0 or req=0: stay in IDLE with outputs zero.
- GRANT: gnt, sel and valid are held stable. Release conditions are checked each edge, in priority order:
  - (a) done=1, or req[sel]=0 -> normal release.
  - (b) otherwise, counter==HOLD_MAX -> forced release; timeout=1 for exactly the next cycle.
  - (c) otherwise, counter increments.
  - If (a) and (b) occur in the same cycle, (a) wins and timeout stays 0.
  - ena=0 does not cut an active grant.
- Any release:
  - Next edge: gnt=0, valid=0, sel keeps its last value, state=RELEASE.
  - ptr=(w+1) mod 8, wrapping so that w=7 gives ptr=0.
- RELEASE:
  - One mandatory idle cycle, then IDLE unconditionally.
  - No grant in this cycle even if requests are pending. This guarantees gnt is never nonzero for two different owners on adjacent cycles.
- Throughput: the minimum repeat period is 3 cycles per grant (IDLE, GRANT, RELEASE).
- Invariants:
  - gnt is always 0 or one-hot.
  - valid == (gnt != 0).
  - When valid=1, gnt == 1<<sel.
- Inputs: only bits at logic 1 count as requests. X/Z on req is illegal stimulus and its behaviour is unspecified.
- ptr updates only on a release. It is unaffected by ena or by idle cycles.

Test Plan:
- Reset then single request: rst_n=0 -> 1, ena=1, req=8'b0000_0100 -> one cycle later gnt=8'b0000_0100, sel=3'b010, valid=1; done pulse -> gnt=0 next cycle, then ptr=3.
- Rotation with all requesters active: req=8'hFF held, done pulsed on every GRANT cycle -> sel sequence 0,1,2,...,7,0, each grant separated by one RELEASE and one IDLE cycle.
- Rotation skips idle bits: after serving requester 2, req=8'b1000_0011 -> next grant is sel=3'b111 (gnt=8'h80); after that, sel=3'b000.
- Timeout: HOLD_MAX=16, req=8'h01 held, no done -> gnt stays high for 16 cycles, then timeout=1 for one cycle together with gnt=0; next grant goes to sel=0 again only after RELEASE and IDLE.
- Enable gating: ena=0, req=8'h10 -> gnt stays 0 indefinitely. Set ena=1 -> gnt=8'h10, sel=3'b100. Drop ena=0 during GRANT -> grant is held until done.
- Async reset mid-grant: pulse rst_n low between clock edges while gnt=8'h20 -> gnt=0, valid=0, sel=0 immediately with no clock edge needed; after release with req=8'hFF, the first grant is sel=0.
